// File: rtl/merger_p.sv
// merger_p: two-way streaming merger of ascending runs, each run closed by an all-zero record.
// Define MERGER_P_STATS_EN to add the o_rec_count / o_run_count statistics ports.

module merger_p_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign cnt_nxt = cnt + CW'(do_push) - CW'(do_pop);

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // full is registered so upstream read never sees a same-cycle pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt  <= cnt_nxt;
      full <= (cnt_nxt == CW'(DEPTH));
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);

endmodule

module merger_p #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned KEY_W      = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_fifo_1,
  input  logic              i_fifo_1_empty,
  output logic              o_fifo_1_read,
  input  logic [DATA_W-1:0] i_fifo_2,
  input  logic              i_fifo_2_empty,
  output logic              o_fifo_2_read,
  input  logic              i_fifo_out_ready,
  output logic              o_out_fifo_write,
  output logic [DATA_W-1:0] o_data
`ifdef MERGER_P_STATS_EN
  ,
  output logic [31:0]       o_rec_count,
  output logic [31:0]       o_run_count
`endif
);

  typedef enum logic [1:0] {
    ST_MERGE   = 2'd0,
    ST_DRAIN_A = 2'd1,
    ST_DRAIN_B = 2'd2,
    ST_TERM    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic              empty_a;
  logic              empty_b;
  logic              full_a;
  logic              full_b;
  logic              pop_a;
  logic              pop_b;
  logic              emit;
  logic [DATA_W-1:0] emit_data;

  logic [KEY_W-1:0]  key_a;
  logic [KEY_W-1:0]  key_b;
  logic              zero_a;
  logic              zero_b;
  logic              a_le_b;

  assign o_fifo_1_read = ~i_fifo_1_empty & ~full_a & ~i_rst;
  assign o_fifo_2_read = ~i_fifo_2_empty & ~full_b & ~i_rst;

  merger_p_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo_a (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (o_fifo_1_read),
    .push_data (i_fifo_1),
    .pop       (pop_a),
    .head      (head_a),
    .empty     (empty_a),
    .full      (full_a)
  );

  merger_p_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo_b (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (o_fifo_2_read),
    .push_data (i_fifo_2),
    .pop       (pop_b),
    .head      (head_b),
    .empty     (empty_b),
    .full      (full_b)
  );

  // Only the key field takes part in ordering; ties go to stream A.
  assign key_a  = head_a[DATA_W-1 -: KEY_W];
  assign key_b  = head_b[DATA_W-1 -: KEY_W];
  assign a_le_b = (key_a <= key_b);
  assign zero_a = (head_a == '0);
  assign zero_b = (head_b == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_MERGE;
    end else begin
      state <= state_nxt;
    end
  end

  // Nothing moves unless downstream is ready and every head the state needs is present.
  always_comb begin
    state_nxt = state;
    pop_a     = 1'b0;
    pop_b     = 1'b0;
    emit      = 1'b0;
    emit_data = '0;
    case (state)
      ST_MERGE: begin
        if (i_fifo_out_ready && !empty_a && !empty_b) begin
          if (zero_a && zero_b) begin
            pop_a = 1'b1;
            pop_b = 1'b1;
            emit  = 1'b1;
          end else if (zero_a) begin
            state_nxt = ST_DRAIN_B;
          end else if (zero_b) begin
            state_nxt = ST_DRAIN_A;
          end else if (a_le_b) begin
            pop_a     = 1'b1;
            emit      = 1'b1;
            emit_data = head_a;
          end else begin
            pop_b     = 1'b1;
            emit      = 1'b1;
            emit_data = head_b;
          end
        end
      end
      ST_DRAIN_A: begin
        if (i_fifo_out_ready && !empty_a) begin
          if (zero_a) begin
            state_nxt = ST_TERM;
          end else begin
            pop_a     = 1'b1;
            emit      = 1'b1;
            emit_data = head_a;
          end
        end
      end
      ST_DRAIN_B: begin
        if (i_fifo_out_ready && !empty_b) begin
          if (zero_b) begin
            state_nxt = ST_TERM;
          end else begin
            pop_b     = 1'b1;
            emit      = 1'b1;
            emit_data = head_b;
          end
        end
      end
      ST_TERM: begin
        if (i_fifo_out_ready && !empty_a && !empty_b) begin
          pop_a     = 1'b1;
          pop_b     = 1'b1;
          emit      = 1'b1;
          state_nxt = ST_MERGE;
        end
      end
      default: begin
        state_nxt = ST_MERGE;
      end
    endcase
  end

  // o_data holds its last value whenever nothing is emitted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_out_fifo_write <= 1'b0;
      o_data           <= '0;
    end else begin
      o_out_fifo_write <= emit;
      if (emit) begin
        o_data <= emit_data;
      end
    end
  end

`ifdef MERGER_P_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rec_count <= 32'd0;
      o_run_count <= 32'd0;
    end else if (emit) begin
      if (emit_data == '0) begin
        o_run_count <= o_run_count + 32'd1;
      end else begin
        o_rec_count <= o_rec_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_merger_p.sv
// Bench for merger_p: upstream FIFOs modelled as queues, outputs checked against an expected-record queue.
`timescale 1ns/1ps
module tb_merger_p;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [DATA_W-1:0] f1_data;
  logic [DATA_W-1:0] f2_data;
  logic              f1_empty;
  logic              f2_empty;
  logic              ready;

  logic              rd1_a, rd2_a, wr_a;
  logic [DATA_W-1:0] data_a;
  logic              rd1_b, rd2_b, wr_b;
  logic [DATA_W-1:0] data_b;
`ifdef MERGER_P_STATS_EN
  logic [31:0]       rec_a, run_a, rec_b, run_b;
`endif

  bit                sel;
  logic              rd1, rd2, wr;
  logic [DATA_W-1:0] data;

  logic [DATA_W-1:0] up1[$];
  logic [DATA_W-1:0] up2[$];
  logic [DATA_W-1:0] exp_q[$];
  int                n_cmp = 0;
  int                n_bad = 0;

  merger_p #(.DATA_W(DATA_W), .KEY_W(32), .FIFO_DEPTH(DEPTH)) dut_k32 (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_fifo_1         (f1_data),
    .i_fifo_1_empty   (f1_empty),
    .o_fifo_1_read    (rd1_a),
    .i_fifo_2         (f2_data),
    .i_fifo_2_empty   (f2_empty),
    .o_fifo_2_read    (rd2_a),
    .i_fifo_out_ready (ready),
    .o_out_fifo_write (wr_a),
    .o_data           (data_a)
`ifdef MERGER_P_STATS_EN
    ,
    .o_rec_count      (rec_a),
    .o_run_count      (run_a)
`endif
  );

  merger_p #(.DATA_W(DATA_W), .KEY_W(16), .FIFO_DEPTH(DEPTH)) dut_k16 (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_fifo_1         (f1_data),
    .i_fifo_1_empty   (f1_empty),
    .o_fifo_1_read    (rd1_b),
    .i_fifo_2         (f2_data),
    .i_fifo_2_empty   (f2_empty),
    .o_fifo_2_read    (rd2_b),
    .i_fifo_out_ready (ready),
    .o_out_fifo_write (wr_b),
    .o_data           (data_b)
`ifdef MERGER_P_STATS_EN
    ,
    .o_rec_count      (rec_b),
    .o_run_count      (run_b)
`endif
  );

  assign rd1  = sel ? rd1_b  : rd1_a;
  assign rd2  = sel ? rd2_b  : rd2_a;
  assign wr   = sel ? wr_b   : wr_a;
  assign data = sel ? data_b : data_a;

  // Upstream FIFO model: pop on the edge where the selected DUT reads.
  always @(posedge clk) begin
    logic [DATA_W-1:0] dummy;
    if (rd1 && up1.size() > 0) dummy = up1.pop_front();
    if (rd2 && up2.size() > 0) dummy = up2.pop_front();
  end

  always @(negedge clk) begin
    f1_empty = (up1.size() == 0);
    f2_empty = (up2.size() == 0);
    f1_data  = f1_empty ? '0 : up1[0];
    f2_data  = f2_empty ? '0 : up2[0];
  end

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    ready = 1'b1;
    up1.delete(); up2.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    up1 = '{32'h11};
    up2 = '{32'h22};
    repeat (3) begin
      @(negedge clk); #1;
      n_cmp++;
      if (wr_a !== 1'b0 || data_a !== '0 || wr_b !== 1'b0 || data_b !== '0) begin
        n_bad++;
        $display("FAIL reset_out: got wr=%b/%b data=%h/%h, expected 0", wr_a, wr_b, data_a, data_b);
      end
      n_cmp++;
      if ({rd1_a, rd2_a, rd1_b, rd2_b} !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_read: got reads=%b, expected 0000", {rd1_a, rd2_a, rd1_b, rd2_b});
      end
    end
    up1.delete(); up2.delete();
    @(negedge clk); #1;
    rst = 1'b0;
`ifdef MERGER_P_STATS_EN
    n_cmp++;
    if (rec_a !== 32'd0 || run_a !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_stats: got rec=%0d run=%0d, expected 0/0", rec_a, run_a);
    end
`endif
    repeat (4) begin
      @(negedge clk); #1;
      n_cmp++;
      if (wr_a !== 1'b0 || data_a !== '0 || rd1_a !== 1'b0 || rd2_a !== 1'b0) begin
        n_bad++;
        $display("FAIL idle: got wr=%b data=%h rd=%b%b, expected all 0", wr_a, data_a, rd1_a, rd2_a);
      end
    end
  endtask

  task automatic test_basic();
    int first_rd = -1;
    int first_wr = -1;
    int last_wr  = -1;
    logic [DATA_W-1:0] e;
    sel = 1'b0;
    do_reset();
    up1   = '{32'd1, 32'd4, 32'd6, 32'd0};
    up2   = '{32'd2, 32'd3, 32'd7, 32'd0};
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd6, 32'd7, 32'd0};
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk); #1;
      if (first_rd < 0 && (rd1 || rd2)) first_rd = cyc;
      if (wr) begin
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL basic_extra: got %h, expected no write", data);
        end else begin
          e = exp_q.pop_front();
          if (data !== e) begin
            n_bad++;
            $display("FAIL basic_data: got %h, expected %h", data, e);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL basic_missing: got %0d records left, expected 0", exp_q.size());
    end
    n_cmp++;
    if (first_wr - first_rd != 2) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d cycles, expected 2", first_wr - first_rd);
    end
    // five back-to-back emits, bubble into DRAIN_B, emit 7, bubble into TERM, emit 0
    n_cmp++;
    if (last_wr - first_wr != 8) begin
      n_bad++;
      $display("FAIL basic_span: got %0d cycles, expected 8", last_wr - first_wr);
    end
  endtask

  task automatic test_ties();
    logic [DATA_W-1:0] e;
    sel = 1'b1;
    do_reset();
    up1   = '{32'h0005_0001, 32'h0, 32'h0003_0009, 32'h0};
    up2   = '{32'h0005_0002, 32'h0009_0000, 32'h0, 32'h0003_0002, 32'h0};
    exp_q = '{32'h0005_0001, 32'h0005_0002, 32'h0009_0000, 32'h0,
              32'h0003_0009, 32'h0003_0002, 32'h0};
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk); #1;
      if (wr) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL ties_extra: got %h, expected no write", data);
        end else begin
          e = exp_q.pop_front();
          if (data !== e) begin
            n_bad++;
            $display("FAIL ties_data: got %h, expected %h", data, e);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL ties_missing: got %0d records left, expected 0", exp_q.size());
    end
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] last_data = '0;
    logic              rdy_prev  = 1'b1;
    sel = 1'b0;
    do_reset();
    up1   = '{32'd1, 32'd4, 32'd6, 32'd0};
    up2   = '{32'd2, 32'd3, 32'd7, 32'd0};
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd6, 32'd7, 32'd0};
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk); #1;
      if (wr) begin
        n_cmp++;
        if (!rdy_prev) begin
          n_bad++;
          $display("FAIL bp_not_ready: got write with ready=0, expected no write");
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL bp_extra: got %h, expected no write", data);
        end else begin
          e = exp_q.pop_front();
          if (data !== e) begin
            n_bad++;
            $display("FAIL bp_data: got %h, expected %h", data, e);
          end
        end
        last_data = data;
      end else if (cyc % 8 == 0) begin
        n_cmp++;
        if (data !== last_data) begin
          n_bad++;
          $display("FAIL bp_hold: got %h, expected %h", data, last_data);
        end
      end
      ready    = (cyc % 3 == 2);
      rdy_prev = ready;
    end
    ready = 1'b1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_missing: got %0d records left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_full_reset();
    int captures = 0;
    int writes   = 0;
    logic [DATA_W-1:0] e;
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < DEPTH + 4; i++) up1.push_back(DATA_W'(i + 1));
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk); #1;
      if (rd1) captures++;
      if (wr) writes++;
    end
    n_cmp++;
    if (captures != DEPTH) begin
      n_bad++;
      $display("FAIL full_captures: got %0d, expected %0d", captures, DEPTH);
    end
    n_cmp++;
    if (rd1 !== 1'b0 || up1.size() != 4) begin
      n_bad++;
      $display("FAIL full_blocked: got rd=%b left=%0d, expected rd=0 left=4", rd1, up1.size());
    end
    n_cmp++;
    if (writes != 0) begin
      n_bad++;
      $display("FAIL full_writes: got %0d, expected 0", writes);
    end
    do_reset();
    up1   = '{32'd1, 32'd0};
    up2   = '{32'd2, 32'd0};
    exp_q = '{32'd1, 32'd2, 32'd0};
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk); #1;
      if (wr) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL after_rst_extra: got %h, expected no write", data);
        end else begin
          e = exp_q.pop_front();
          if (data !== e) begin
            n_bad++;
            $display("FAIL after_rst_data: got %h, expected %h", data, e);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL after_rst_missing: got %0d records left, expected 0", exp_q.size());
    end
  endtask

`ifdef MERGER_P_STATS_EN
  task automatic test_stats();
    logic [DATA_W-1:0] e;
    sel = 1'b0;
    do_reset();
    up1   = '{32'd1, 32'd4, 32'd6, 32'd0, 32'd1, 32'd4, 32'd6, 32'd0};
    up2   = '{32'd2, 32'd3, 32'd7, 32'd0, 32'd2, 32'd3, 32'd7, 32'd0};
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd6, 32'd7, 32'd0,
              32'd1, 32'd2, 32'd3, 32'd4, 32'd6, 32'd7, 32'd0};
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk); #1;
      if (wr) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL stats_extra: got %h, expected no write", data);
        end else begin
          e = exp_q.pop_front();
          if (data !== e) begin
            n_bad++;
            $display("FAIL stats_data: got %h, expected %h", data, e);
          end
        end
      end
    end
    n_cmp++;
    if (rec_a !== 32'd12 || run_a !== 32'd2) begin
      n_bad++;
      $display("FAIL stats_counts: got rec=%0d run=%0d, expected 12/2", rec_a, run_a);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    ready    = 1'b1;
    sel      = 1'b0;
    f1_empty = 1'b1;
    f2_empty = 1'b1;
    f1_data  = '0;
    f2_data  = '0;
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_full_reset();
`ifdef MERGER_P_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
